// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types, defaults and frame-length helper for the DDS UART transmitter
package dds_pkg;

   localparam int DEFAULT_DATA_BITS = 8;
   localparam int DEFAULT_STOP_BITS = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      PAR   = 3'd4,
      STOP  = 3'd5
   } tx_state_e;

   // Number of bit periods (ticks) one complete frame occupies on the line.
   function automatic int frame_ticks(input int data_bits, input int stop_bits, input bit parity);
      return 1 + data_bits + (parity ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/dds_tx_shift.sv
// rtl/dds_tx_shift.sv - load/shift register and even-parity accumulator (parity with DDS_UART_TX_PARITY_EN)
module dds_tx_shift
   import dds_pkg::*;
#(
   parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 shift,
   input  logic [DATA_BITS-1:0] load_data,
   output logic                 lsb,
   output logic                 next_lsb
`ifdef DDS_UART_TX_PARITY_EN
   ,
   output logic                 parity
`endif
);

   logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef DDS_UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   // Load has priority: a new word replaces whatever is left of the previous one.
   always_comb begin
      shift_d = shift_q;
      if (load) begin
         shift_d = load_data;
      end else if (shift) begin
         shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
      end
   end

`ifdef DDS_UART_TX_PARITY_EN
   // Parity is taken once from the word as latched, independent of shifting.
   always_comb begin
      parity_d = parity_q;
      if (load) begin
         parity_d = ^load_data;
      end
   end
`endif

   // Register update.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
`ifdef DDS_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         shift_q <= shift_d;
`ifdef DDS_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign lsb      = shift_q[0];
   assign next_lsb = shift_q[1];
`ifdef DDS_UART_TX_PARITY_EN
   assign parity   = parity_q;
`endif

endmodule

// File: rtl/dds_uart_tx.sv
// rtl/dds_uart_tx.sv - tick-paced UART transmitter FSM and handshake (parity with DDS_UART_TX_PARITY_EN)
module dds_uart_tx
   import dds_pkg::*;
#(
   parameter int DATA_BITS = DEFAULT_DATA_BITS,
   parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 busy
);

   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e  state_q, state_d;
   logic       txd_q, txd_d;
   logic       busy_q, busy_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic       pend_q, pend_d;

   logic       final_stop;
   logic       xfer;
   logic       shift;
   logic       sh_lsb;
   logic       sh_next;
`ifdef DDS_UART_TX_PARITY_EN
   logic       sh_parity;
`endif

   // A word can be taken while idle, or during the last stop bit so the next
   // frame can follow without an idle gap.
   assign final_stop = (state_q == STOP) && (stop_cnt_q == LAST_STOP);
   assign tx_ready   = !rst && ((state_q == IDLE) || (final_stop && !pend_q));
   assign xfer       = tx_valid && tx_ready;

   dds_tx_shift #(
      .DATA_BITS (DATA_BITS)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (xfer),
      .shift     (shift),
      .load_data (tx_data),
      .lsb       (sh_lsb),
      .next_lsb  (sh_next)
`ifdef DDS_UART_TX_PARITY_EN
      ,
      .parity    (sh_parity)
`endif
   );

   // Next-state and line value; everything except the handshake advances only on tick.
   always_comb begin
      state_d    = state_q;
      txd_d      = txd_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      pend_d     = pend_q;
      shift      = 1'b0;
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (xfer) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (tick) begin
               state_d = START;
               txd_d   = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               txd_d     = sh_lsb;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q != LAST_BIT) begin
                  shift     = 1'b1;
                  txd_d     = sh_next;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else begin
`ifdef DDS_UART_TX_PARITY_EN
                  state_d = PAR;
                  txd_d   = sh_parity;
`else
                  state_d    = STOP;
                  txd_d      = 1'b1;
                  stop_cnt_d = 1'b0;
`endif
               end
            end
         end
`ifdef DDS_UART_TX_PARITY_EN
         PAR: begin
            if (tick) begin
               state_d    = STOP;
               txd_d      = 1'b1;
               stop_cnt_d = 1'b0;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (stop_cnt_q != LAST_STOP) begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end else if (pend_q || xfer) begin
                  // A word taken on this same edge starts directly rather than being parked.
                  state_d = START;
                  txd_d   = 1'b0;
                  pend_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer) begin
               pend_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
      busy_d = (state_d != IDLE) || pend_d;
   end

   // State register; reset aborts any frame and drops a pending word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         pend_q     <= pend_d;
      end
   end

   assign txd  = txd_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_dds_uart_tx.sv
// tb/tb_dds_uart_tx.sv - self-checking bench for dds_uart_tx against a frame-level model
module tb_dds_uart_tx;

   localparam int D = 8;
   localparam int S = 1;
`ifdef DDS_UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int L = 1 + D + P + S;

   logic         clk = 1'b0;
   logic         rst;
   logic         tick;
   logic [D-1:0] tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         txd;
   logic         busy;

   always #5 clk = ~clk;

   dds_uart_tx #(
      .DATA_BITS (D),
      .STOP_BITS (S)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .txd      (txd),
      .busy     (busy)
   );

   int checks = 0;
   int errors = 0;

   // Frame-level model: which word is on the line and how many ticks of it have elapsed.
   bit           m_active = 1'b0;
   int           m_n      = 0;
   logic [D-1:0] m_cur    = '0;
   logic [D-1:0] m_pend   = '0;
   bit           m_pend_v = 1'b0;
   int           tph      = 0;

   // Bit idx of the frame for word w: start, data LSB-first, optional even parity, stop bits.
   function automatic logic frame_bit(input logic [D-1:0] w, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= D) return w[idx-1];
      if (P == 1 && idx == D + 1) return ^w;
      return 1'b1;
   endfunction

   function automatic bit next_tick(input int mode);
      bit t;
      case (mode)
         0: t = 1'b1;
         1: t = ((tph % 5) % 2) == 0;
         default: t = ($urandom_range(0, 3) == 0);
      endcase
      tph++;
      return t;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=cycle budget expired expected=completion", tag);
   endtask

   // One clock: drive inputs, check ready before the edge, advance model, check line and busy after.
   task automatic cyc(input bit t, input bit v, input logic [D-1:0] d, input bit r, output bit xf);
      bit   exp_rdy;
      logic exp_txd;
      tick = t; tx_valid = v; tx_data = d; rst = r;
      #1;
      exp_rdy = !r && (!m_active || (m_n == L && !m_pend_v));
      check("tx_ready", tx_ready, exp_rdy);
      xf = v && exp_rdy;
      @(posedge clk);
      #1;
      if (r) begin
         m_active = 1'b0; m_pend_v = 1'b0; m_n = 0;
      end else if (!m_active) begin
         if (xf) begin m_active = 1'b1; m_cur = d; m_n = 0; end
      end else if (t) begin
         if (m_n < L) m_n++;
         else if (m_pend_v) begin m_cur = m_pend; m_pend_v = 1'b0; m_n = 1; end
         else if (xf) begin m_cur = d; m_n = 1; end
         else m_active = 1'b0;
      end else if (xf) begin
         m_pend = d; m_pend_v = 1'b1;
      end
      exp_txd = (m_active && m_n > 0) ? frame_bit(m_cur, m_n - 1) : 1'b1;
      check("txd", txd, exp_txd);
      check("busy", busy, m_active || m_pend_v);
   endtask

   task automatic send(input logic [D-1:0] w, input int mode, input bit rand_valid);
      bit xf = 1'b0;
      int k = 0;
      while (!xf && k < 400) begin
         cyc(next_tick(mode), rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1, w, 1'b0, xf);
         k++;
      end
      if (!xf) timeout("send");
   endtask

   task automatic drain(input int mode);
      bit xf;
      int k = 0;
      while ((m_active || m_pend_v) && k < 400) begin
         cyc(next_tick(mode), 1'b0, D'($urandom), 1'b0, xf);
         k++;
      end
      if (m_active || m_pend_v) timeout("drain");
   endtask

   task automatic advance_to(input int n);
      bit xf;
      int k = 0;
      while (m_n < n && k < 100) begin
         cyc(1'b1, 1'b0, '0, 1'b0, xf);
         k++;
      end
      if (m_n < n) timeout("advance");
   endtask

   initial begin
      bit xf;
      rst = 1'b1; tick = 1'b0; tx_valid = 1'b0; tx_data = '0;

      // Reset held with valid asserted and tick toggling.
      for (int i = 0; i < 3; i++) cyc(i[0], 1'b1, D'($urandom), 1'b1, xf);
      cyc(1'b0, 1'b0, '0, 1'b0, xf);

      // Single frame, tick every cycle.
      send(8'hA5, 0, 1'b0);
      drain(0);

      // Fractional 3-of-5 tick pattern.
      tph = 0;
      send(8'h3C, 1, 1'b0);
      drain(1);

      // Back-to-back with valid held.
      send(8'h55, 0, 1'b0);
      send(8'h0F, 0, 1'b0);
      drain(0);

      // Parity-sensitive words.
      send(8'h07, 0, 1'b0);
      drain(0);
      send(8'h03, 1, 1'b0);
      drain(1);

      // Randomized words, tick density and valid drops.
      for (int i = 0; i < 30; i++) begin
         send(D'($urandom), 2, 1'b1);
         if ($urandom_range(0, 1) == 0) drain(2);
      end
      drain(2);

      // Reset during data bit 4 of 0xFF with valid presented.
      send(8'hFF, 0, 1'b0);
      advance_to(6);
      cyc(1'b1, 1'b1, 8'h81, 1'b1, xf);
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, '0, 1'b0, xf);

      // Reset while a word is pending in the final stop bit.
      send(8'h00, 0, 1'b0);
      advance_to(L);
      cyc(1'b0, 1'b1, 8'hFF, 1'b0, xf);
      cyc(1'b0, 1'b0, '0, 1'b0, xf);
      cyc(1'b1, 1'b0, '0, 1'b1, xf);
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, '0, 1'b0, xf);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
